rotate_sequencer: RTL and testbench
===================================

# rotate_sequencer

Controller that sequences the team's `shift_register` rotating datapath. It loads a seed pattern, then issues a programmed number of rotate steps at a programmable rate, in a fixed direction or bouncing (ping-pong). It sits between the PWM loop's control logic and the shift register. Control logic issues a start/done handshake; the rotating pattern drives downstream PWM/LED channel enables.

## Interface
Parameters:
- `WIDTH`, 8: pattern width; also the width of the internal `shift_register`.
- `CNT_W`, 8: width of the step-count input.
- `DIV_W`, 8: width of the rate-divider input.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request a run; sampled only in IDLE.
- `stop`  in  1  abort the current run; ignored in IDLE.
- `pattern`  in  WIDTH  seed value, captured on an accepted start.
- `steps`  in  CNT_W  number of rotate steps N, captured on start.
- `div`  in  DIV_W  rate divider D, captured on start.
- `mode`  in  2  rotate mode, captured on start:
  - 00: left.
  - 01: right.
  - 10: ping-pong, first direction left.
  - 11: ping-pong, first direction right.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when a run completes normally.
- `pattern_out`  out  WIDTH  `data_out` of the internal shift register.

## Operation
- FSM states: IDLE, LOAD, WAIT, SHIFT, DONE.
- IDLE:
  - On `start`=1, capture `pattern`, `steps`, `div` and `mode`, then go to LOAD.
  - `start` is ignored in every other state.
- LOAD:
  - Drive `load`=1 and `shift`=0 to the shift register for exactly one cycle.
  - Preload the prescaler with D.
  - If N==0, go to DONE; otherwise go to WAIT.
- WAIT:
  - Decrement the prescaler each cycle.
  - When the prescaler reads 0, go to SHIFT. WAIT therefore lasts D+1 cycles.
- SHIFT:
  - Drive `shift`=1 and `dir`=current direction (0=left, 1=right) for one cycle. The rotation is circular.
  - Decrement the remaining-step counter.
  - If the counter reaches 0, go to DONE; otherwise reload the prescaler with D and go to WAIT.
- Ping-pong:
  - A bounce counter counts shifts in the current direction.
  - After WIDTH-1 shifts, direction toggles and the bounce counter clears.
- DONE: assert `done` for one cycle, then go to IDLE.
- `stop`:
  - In LOAD, WAIT or SHIFT, the next state is IDLE.
  - No `done` pulse is issued.
  - `pattern_out` holds its current value.
  - Any SHIFT in progress in that same cycle still takes effect.
- `stop` and `start` together in IDLE: `start` wins.
- `load` and `shift` are never asserted in the same cycle.

## Timing
- Reset values:
  - State IDLE; `busy`=0, `done`=0, `pattern_out`=0.
  - All counters 0; direction 0.
- Reset mid-run: IDLE on the next edge; no `done` pulse.
- Cycle numbering: cycle 0 is the cycle in which `start` is sampled in IDLE.
  - LOAD is cycle 1; `pattern_out`=seed from cycle 2.
  - Step k (k=1..N) is SHIFT at cycle 1+k·(D+2); the rotated value is visible the following cycle.
  - `done` is high in cycle 2+N·(D+2). For N=0, `done` is high in cycle 2.
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- A new `start` can be accepted in the first cycle after DONE.
- Counter widths: the step counter is CNT_W bits and the prescaler DIV_W bits. N and D are unsigned; no wrap occurs because both count down from captured values.

## Structure
- Shared package `rotate_seq_pkg` holds:
  - the FSM state enum;
  - mode encodings (`MODE_LEFT`, `MODE_RIGHT`, `MODE_PP_L`, `MODE_PP_R`);
  - direction constants `DIR_LEFT`=0 and `DIR_RIGHT`=1.
- One sub-module: the existing `shift_register` (WIDTH-parameterised, ports `clk`, `rst`, `load`, `shift`, `dir`, `data_in`, `data_out`), instantiated once.
  - `data_in` is driven by the captured seed.
- The FSM, prescaler, step counter and bounce counter stay in the top module.

## Test plan
- Left rotate: seed 8'h01, mode 00, N=3, D=0 → `pattern_out` is 8'h02, 8'h04, 8'h08; `done` in cycle 8; `busy` falls in cycle 9.
- Right rotate with rate divider: seed 8'h01, mode 01, N=2, D=3 → 8'h80 then 8'h40; shifts at cycles 6 and 11; `done` in cycle 12.
- Ping-pong: seed 8'h01, mode 10, N=9, D=0 → 8'h80 after 7 steps, then 8'h40 and 8'h20; `done` in cycle 20.
- N=0: seed 8'hA5 → `pattern_out`=8'hA5 from cycle 2; `done` in cycle 2; no shift pulses.
- Stop mid-run: seed 8'h01, mode 00, N=5, D=2; pulse `stop` in cycle 10 → `pattern_out` holds 8'h04; `busy`=0 from cycle 11; no `done` pulse. A following `start` is accepted.
- Start while busy, and reset: `start` re-pulsed mid-run is ignored (step count unchanged). `rst` asserted mid-run → next cycle `busy`=0, `pattern_out`=0, no `done` pulse.

Source files
------------

// File: rtl/rotate_seq_pkg.sv
// Shared definitions for the rotate sequencer: FSM states, mode encodings,
// rotation direction constants and small mode-decoding helpers.
package rotate_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam logic [1:0] MODE_LEFT  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_PP_L  = 2'b10;
   localparam logic [1:0] MODE_PP_R  = 2'b11;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   // Ping-pong modes share the upper mode bit.
   function automatic logic mode_is_pp(input logic [1:0] m);
      return m[1];
   endfunction

   // The lower mode bit selects the (initial) rotation direction.
   function automatic logic mode_first_dir(input logic [1:0] m);
      return m[0] ? DIR_RIGHT : DIR_LEFT;
   endfunction

endpackage

// File: rtl/shift_register.sv
// Circular shift register: synchronous load of a seed, one-position rotate
// left or right per shift pulse. Load takes priority over shift.
module shift_register #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic             dir,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   // Next value: load the seed, rotate by one position, or hold.
   always_comb begin
      data_d = data_q;
      if (load) begin
         data_d = data_in;
      end else if (shift) begin
         if (dir == 1'b1) begin
            data_d = {data_q[0], data_q[WIDTH-1:1]};
         end else begin
            data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
         end
      end else begin
         data_d = data_q;
      end
   end

   // Pattern register with synchronous reset to all zeros.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= {WIDTH{1'b0}};
      end else begin
         data_q <= data_d;
      end
   end

   assign data_out = data_q;

endmodule

// File: rtl/rotate_sequencer.sv
// Sequencer for the rotating shift register: captures a run request, loads
// the seed, then issues N rotate steps spaced D+2 cycles apart, either in a
// fixed direction or bouncing back and forth every WIDTH-1 steps.
module rotate_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8,
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] pattern,
   input  logic [CNT_W-1:0] steps,
   input  logic [DIV_W-1:0] div,
   input  logic [1:0]       mode,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] pattern_out
);

   import rotate_seq_pkg::*;

   // Bounce counter must reach WIDTH-2 before a direction change.
   localparam int BNC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [BNC_W-1:0] BNC_ZERO  = {BNC_W{1'b0}};
   localparam logic [BNC_W-1:0] BNC_ONE   = {{(BNC_W-1){1'b0}}, 1'b1};
   localparam logic [BNC_W-1:0] BNC_LAST  = BNC_W'(WIDTH - 2);
   localparam logic [CNT_W-1:0] STEP_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] STEP_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [DIV_W-1:0] DIV_ZERO  = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0] DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic [CNT_W-1:0] steps_q, steps_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic [BNC_W-1:0] bounce_q, bounce_d;
   logic             pp_q, pp_d;
   logic             dir_q, dir_d;
   logic             busy_q, done_q;
   logic             sr_load_s, sr_shift_s;

   // Next-state, counter updates and shift-register strobes.
   always_comb begin
      state_d    = state_q;
      seed_d     = seed_q;
      steps_d    = steps_q;
      div_d      = div_q;
      presc_d    = presc_q;
      bounce_d   = bounce_q;
      pp_d       = pp_q;
      dir_d      = dir_q;
      sr_load_s  = 1'b0;
      sr_shift_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               seed_d   = pattern;
               steps_d  = steps;
               div_d    = div;
               pp_d     = mode_is_pp(mode);
               dir_d    = mode_first_dir(mode);
               bounce_d = BNC_ZERO;
               state_d  = ST_LOAD;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_LOAD: begin
            sr_load_s = 1'b1;
            presc_d   = div_q;
            if (stop) begin
               state_d = ST_IDLE;
            end else if (steps_q == STEP_ZERO) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (presc_q == DIV_ZERO) begin
               state_d = ST_SHIFT;
            end else begin
               presc_d = presc_q - DIV_ONE;
               state_d = ST_WAIT;
            end
            if (stop) begin
               state_d = ST_IDLE;
            end else begin
               state_d = state_d;
            end
         end
         ST_SHIFT: begin
            // The shift itself is not cancelled by stop.
            sr_shift_s = 1'b1;
            steps_d    = steps_q - STEP_ONE;
            if (pp_q) begin
               if (bounce_q == BNC_LAST) begin
                  dir_d    = ~dir_q;
                  bounce_d = BNC_ZERO;
               end else begin
                  bounce_d = bounce_q + BNC_ONE;
               end
            end else begin
               bounce_d = BNC_ZERO;
            end
            if (stop) begin
               state_d = ST_IDLE;
            end else if (steps_q == STEP_ONE) begin
               state_d = ST_DONE;
            end else begin
               presc_d = div_q;
               state_d = ST_WAIT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, captured run parameters, counters and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         seed_q   <= {WIDTH{1'b0}};
         steps_q  <= STEP_ZERO;
         div_q    <= DIV_ZERO;
         presc_q  <= DIV_ZERO;
         bounce_q <= BNC_ZERO;
         pp_q     <= 1'b0;
         dir_q    <= DIR_LEFT;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         seed_q   <= seed_d;
         steps_q  <= steps_d;
         div_q    <= div_d;
         presc_q  <= presc_d;
         bounce_q <= bounce_d;
         pp_q     <= pp_d;
         dir_q    <= dir_d;
         busy_q   <= (state_d != ST_IDLE);
         done_q   <= (state_d == ST_DONE);
      end
   end

   shift_register #(
      .WIDTH (WIDTH)
   ) u_shift_register (
      .clk      (clk),
      .rst      (rst),
      .load     (sr_load_s),
      .shift    (sr_shift_s),
      .dir      (dir_q),
      .data_in  (seed_q),
      .data_out (pattern_out)
   );

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_rotate_sequencer.sv
// Directed bench for rotate_sequencer: each run starts in cycle 0, logs the
// outputs of every cycle, then the logged values are compared against
// hand-computed cycle positions and patterns.
module tb_rotate_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic [7:0] pattern;
   logic [7:0] steps;
   logic [7:0] div;
   logic [1:0] mode;
   logic       busy;
   logic       done;
   logic [7:0] pattern_out;

   int n_checks;
   int n_errors;
   int n_done;

   logic [7:0] pat_log  [0:63];
   logic       done_log [0:63];
   logic       busy_log [0:63];

   rotate_sequencer #(
      .WIDTH (8),
      .CNT_W (8),
      .DIV_W (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .pattern     (pattern),
      .steps       (steps),
      .div         (div),
      .mode        (mode),
      .busy        (busy),
      .done        (done),
      .pattern_out (pattern_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One run: start in cycle 0, optional stop / re-start / reset in given cycles.
   task automatic run(input logic [7:0] seed, input logic [1:0] m,
                      input logic [7:0] n, input logic [7:0] d, input int ncyc,
                      input int stop_at, input int restart_at, input int rst_at);
      pattern = seed;
      mode    = m;
      steps   = n;
      div     = d;
      n_done  = 0;
      for (int c = 0; c <= ncyc; c++) begin
         start = (c == 0) || (c == restart_at);
         stop  = (c == stop_at);
         rst   = (c == rst_at);
         if (c == restart_at) begin
            pattern = 8'hF0;
            steps   = 8'd5;
         end
         pat_log[c]  = pattern_out;
         done_log[c] = done;
         busy_log[c] = busy;
         if (done) n_done++;
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      stop  = 1'b0;
      rst   = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      pattern = 8'h00; steps = 8'h00; div = 8'h00; mode = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_pat", pattern_out, 8'h00);

      // Left: shifts at 3,5,7; done in 8.
      run(8'h01, 2'b00, 8'd3, 8'd0, 12, -1, -1, -1);
      chk("left_busy0", busy_log[0], 1'b0);
      chk("left_busy1", busy_log[1], 1'b1);
      chk("left_seed", pat_log[2], 8'h01);
      chk("left_pre1", pat_log[3], 8'h01);
      chk("left_s1", pat_log[4], 8'h02);
      chk("left_s2", pat_log[6], 8'h04);
      chk("left_s3", pat_log[8], 8'h08);
      chk("left_done7", done_log[7], 1'b0);
      chk("left_done8", done_log[8], 1'b1);
      chk("left_busy8", busy_log[8], 1'b1);
      chk("left_busy9", busy_log[9], 1'b0);
      chk("left_ndone", n_done, 1);

      // Right, D=3: shifts at 6 and 11; done in 12.
      run(8'h01, 2'b01, 8'd2, 8'd3, 15, -1, -1, -1);
      chk("right_pre1", pat_log[6], 8'h01);
      chk("right_s1", pat_log[7], 8'h80);
      chk("right_pre2", pat_log[11], 8'h80);
      chk("right_s2", pat_log[12], 8'h40);
      chk("right_done11", done_log[11], 1'b0);
      chk("right_done12", done_log[12], 1'b1);

      // Ping-pong from left: 0x80 after 7 steps, then back right.
      run(8'h01, 2'b10, 8'd9, 8'd0, 24, -1, -1, -1);
      chk("pp_s6", pat_log[14], 8'h40);
      chk("pp_s7", pat_log[16], 8'h80);
      chk("pp_s8", pat_log[18], 8'h40);
      chk("pp_s9", pat_log[20], 8'h20);
      chk("pp_done19", done_log[19], 1'b0);
      chk("pp_done20", done_log[20], 1'b1);
      chk("pp_ndone", n_done, 1);

      // N=0: seed loaded, immediate done, no rotation.
      run(8'hA5, 2'b00, 8'd0, 8'd0, 6, -1, -1, -1);
      chk("n0_seed", pat_log[2], 8'hA5);
      chk("n0_done", done_log[2], 1'b1);
      chk("n0_busy3", busy_log[3], 1'b0);
      chk("n0_hold", pat_log[6], 8'hA5);
      chk("n0_ndone", n_done, 1);

      // Stop in cycle 10 (WAIT after second shift).
      run(8'h01, 2'b00, 8'd5, 8'd2, 25, 10, -1, -1);
      chk("stop_pat10", pat_log[10], 8'h04);
      chk("stop_busy10", busy_log[10], 1'b1);
      chk("stop_busy11", busy_log[11], 1'b0);
      chk("stop_hold", pat_log[20], 8'h04);
      chk("stop_ndone", n_done, 0);

      // Start after stop is accepted: one right rotate of 0x80.
      run(8'h80, 2'b01, 8'd1, 8'd0, 6, -1, -1, -1);
      chk("after_stop_seed", pat_log[2], 8'h80);
      chk("after_stop_s1", pat_log[4], 8'h40);
      chk("after_stop_done", done_log[4], 1'b1);

      // Re-start mid-run with other inputs is ignored: shifts at 4,7; done in 8.
      run(8'h01, 2'b00, 8'd2, 8'd1, 14, -1, 5, -1);
      chk("restart_s1", pat_log[5], 8'h02);
      chk("restart_s2", pat_log[8], 8'h04);
      chk("restart_done", done_log[8], 1'b1);
      chk("restart_busy9", busy_log[9], 1'b0);
      chk("restart_hold", pat_log[14], 8'h04);
      chk("restart_ndone", n_done, 1);

      // Reset in cycle 6: idle and cleared in cycle 7, no done.
      run(8'h01, 2'b00, 8'd5, 8'd0, 16, -1, -1, 6);
      chk("rst_pat6", pat_log[6], 8'h04);
      chk("rst_busy7", busy_log[7], 1'b0);
      chk("rst_pat7", pat_log[7], 8'h00);
      chk("rst_ndone", n_done, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
